immediate_former_pipelined: RTL and testbench

// - Parametrised, pipelined successor to the LUI/AUIPC immediate former. Decodes U/J/B/I immediates

---
 rtl/immediate_former_pipelined_pkg.sv | 40 ++++
 rtl/immediate_former_pipelined_handshake_pipe_stage.sv | 28 ++
 rtl/immediate_former_pipelined.sv | 148 ++++++++++++++
 tb/tb_immediate_former_pipelined.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_former_pipelined_pkg.sv
// Shared types for the immediate former: mode encodings and the RISC-V
// immediate extraction helpers (32-bit, callers widen to XLEN).
package JZJCoreFTypes;

   typedef enum logic [3:0] {
      LUI    = 4'h0,
      AUIPC  = 4'h1,
      JAL    = 4'h2,
      BRANCH = 4'h3,
      JALR   = 4'h4,
      LINK   = 4'h5
   } ImmediateFormerMode_t;

   localparam logic [3:0] LAST_DEFINED_MODE = 4'h5;

   function automatic logic [31:0] immU(input logic [31:0] ins);
      return {ins[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] immJ(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] immB(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] immI(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic isDefinedMode(input logic [3:0] m);
      return m <= LAST_DEFINED_MODE;
   endfunction

   function automatic logic isControlFlow(input logic [3:0] m);
      return (m == JAL) || (m == BRANCH) || (m == JALR);
   endfunction

endpackage

// File: rtl/immediate_former_pipelined_handshake_pipe_stage.sv
// One valid/ready register slice. Ready looks through to the downstream
// ready (no skid buffer), so a full slice can drain and refill in one cycle.
module handshake_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         srcValid,
   output logic         srcReady,
   input  logic [W-1:0] srcData,
   output logic         dstValid,
   input  logic         dstReady,
   output logic [W-1:0] dstData
);

   assign srcReady = !dstValid || dstReady;

   always_ff @(posedge clock) begin
      if (reset) begin
         dstValid <= 1'b0;
         dstData  <= '0;
      end else if (srcReady) begin
         dstValid <= srcValid;
         if (srcValid) dstData <= srcData;
      end
   end

endmodule

// File: rtl/immediate_former_pipelined.sv
// Forms LUI/AUIPC/JAL/BRANCH/JALR/LINK values behind a valid/ready pipe of
// STAGES slices; with two stages the operand select and the add are split.
import JZJCoreFTypes::*;

module immediate_former_pipelined #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1,
   parameter int TAG_W  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       mode,
   input  logic [31:0]      instruction,
   input  logic [XLEN-1:0]  pc_of_instr,
   input  logic [XLEN-1:0]  rs1_value,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             misaligned,
   output logic             illegal_mode,
   output logic [TAG_W-1:0] out_tag
);

   localparam int FIN_W = XLEN + 2 + TAG_W;
   localparam int SEL_W = 2 * XLEN + 4 + TAG_W;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [XLEN-1:0]  selImm;
   logic [XLEN-1:0]  selBase;
   logic [XLEN-1:0]  finImm;
   logic [XLEN-1:0]  finBase;
   logic [3:0]       finMode;
   logic [TAG_W-1:0] finTag;
   logic [XLEN-1:0]  finResult;
   logic             finMis;
   logic             finIll;
   logic [FIN_W-1:0] outPayload;
   logic             unusedOpcode;

   // The opcode field is implied by mode and never decoded here.
   assign unusedOpcode = ^instruction[6:0];

   // Undefined modes select zero base and zero immediate, so the sum is 0.
   always_comb begin
      selImm  = '0;
      selBase = '0;
      case (ImmediateFormerMode_t'(mode))
         LUI:     selImm = sext32(immU(instruction));
         AUIPC: begin
            selBase = pc_of_instr;
            selImm  = sext32(immU(instruction));
         end
         JAL: begin
            selBase = pc_of_instr;
            selImm  = sext32(immJ(instruction));
         end
         BRANCH: begin
            selBase = pc_of_instr;
            selImm  = sext32(immB(instruction));
         end
         JALR: begin
            selBase = rs1_value;
            selImm  = sext32(immI(instruction));
         end
         LINK: begin
            selBase = pc_of_instr;
            selImm  = XLEN'(4);
         end
         default: ;
      endcase
   end

   always_comb begin
      finResult = finBase + finImm;
      if (finMode == JALR) finResult[0] = 1'b0;
      finIll = !isDefinedMode(finMode);
      finMis = isControlFlow(finMode) && (finResult[1:0] != 2'b00);
   end

   generate
      if (STAGES == 1) begin : gOneStage
         assign finBase = selBase;
         assign finImm  = selImm;
         assign finMode = mode;
         assign finTag  = in_tag;

         handshake_pipe_stage #(.W(FIN_W)) uStage0 (
            .clock    (clock),
            .reset    (reset),
            .srcValid (in_valid),
            .srcReady (in_ready),
            .srcData  ({finResult, finMis, finIll, finTag}),
            .dstValid (out_valid),
            .dstReady (out_ready),
            .dstData  (outPayload)
         );
      end else if (STAGES == 2) begin : gTwoStage
         logic             midValid;
         logic             midReady;
         logic [SEL_W-1:0] midPayload;

         handshake_pipe_stage #(.W(SEL_W)) uStage0 (
            .clock    (clock),
            .reset    (reset),
            .srcValid (in_valid),
            .srcReady (in_ready),
            .srcData  ({selImm, selBase, mode, in_tag}),
            .dstValid (midValid),
            .dstReady (midReady),
            .dstData  (midPayload)
         );

         assign {finImm, finBase, finMode, finTag} = midPayload;

         handshake_pipe_stage #(.W(FIN_W)) uStage1 (
            .clock    (clock),
            .reset    (reset),
            .srcValid (midValid),
            .srcReady (midReady),
            .srcData  ({finResult, finMis, finIll, finTag}),
            .dstValid (out_valid),
            .dstReady (out_ready),
            .dstData  (outPayload)
         );
      end else begin : gBadStages
         $error("immediate_former_pipelined: STAGES must be 1 or 2");
         assign finBase    = '0;
         assign finImm     = '0;
         assign finMode    = '0;
         assign finTag     = '0;
         assign in_ready   = 1'b0;
         assign out_valid  = 1'b0;
         assign outPayload = '0;
      end
   endgenerate

   assign {result, misaligned, illegal_mode, out_tag} = outPayload;

endmodule

// File: tb/tb_immediate_former_pipelined.sv
// Directed bench: one DUT per pipeline depth, exercised in turn with the same
// vector table, single-shot latency checks, streaming, backpressure and reset.
module tb_immediate_former_pipelined;
   import JZJCoreFTypes::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam int NVEC  = 12;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b1;
   logic [3:0]       mode = '0;
   logic [31:0]      instruction = '0;
   logic [XLEN-1:0]  pc_of_instr = '0;
   logic [XLEN-1:0]  rs1_value = '0;
   logic [TAG_W-1:0] in_tag = '0;

   int sel = 0;
   int stagesCur = 1;
   int nChecks = 0;
   int nFail = 0;

   logic v1, r1, ov1, mis1, il1;
   logic v2, r2, ov2, mis2, il2;
   logic [XLEN-1:0]  res1, res2;
   logic [TAG_W-1:0] tg1, tg2;

   logic             obsInReady, obsOutValid, obsMis, obsIll;
   logic [XLEN-1:0]  obsRes;
   logic [TAG_W-1:0] obsTag;

   typedef struct {
      logic [3:0]  m;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] res;
      logic        mis;
      logic        ill;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clock = ~clock;

   assign v1 = in_valid && (sel == 0);
   assign v2 = in_valid && (sel == 1);

   immediate_former_pipelined #(.XLEN(XLEN), .STAGES(1), .TAG_W(TAG_W)) dut1 (
      .clock(clock), .reset(reset), .in_valid(v1), .in_ready(r1), .mode(mode),
      .instruction(instruction), .pc_of_instr(pc_of_instr), .rs1_value(rs1_value),
      .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready), .result(res1),
      .misaligned(mis1), .illegal_mode(il1), .out_tag(tg1)
   );

   immediate_former_pipelined #(.XLEN(XLEN), .STAGES(2), .TAG_W(TAG_W)) dut2 (
      .clock(clock), .reset(reset), .in_valid(v2), .in_ready(r2), .mode(mode),
      .instruction(instruction), .pc_of_instr(pc_of_instr), .rs1_value(rs1_value),
      .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready), .result(res2),
      .misaligned(mis2), .illegal_mode(il2), .out_tag(tg2)
   );

   assign obsInReady  = (sel == 0) ? r1   : r2;
   assign obsOutValid = (sel == 0) ? ov1  : ov2;
   assign obsRes      = (sel == 0) ? res1 : res2;
   assign obsMis      = (sel == 0) ? mis1 : mis2;
   assign obsIll      = (sel == 0) ? il1  : il2;
   assign obsTag      = (sel == 0) ? tg1  : tg2;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL s%0d %s: got %0h expected %0h", stagesCur, tag, got, exp);
      end
   endtask

   task automatic setVec(input int i, input logic [3:0] m, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] res, input logic mis, input logic ill);
      vecs[i].m = m; vecs[i].ins = ins; vecs[i].pc = pc; vecs[i].rs1 = rs1;
      vecs[i].res = res; vecs[i].mis = mis; vecs[i].ill = ill;
   endtask

   task automatic drive(input int i);
      mode        = vecs[i].m;
      instruction = vecs[i].ins;
      pc_of_instr = vecs[i].pc;
      rs1_value   = vecs[i].rs1;
      in_tag      = TAG_W'(i + 1);
   endtask

   task automatic checkOut(input string pfx, input int i);
      checkEq({pfx, "_res"}, obsRes, vecs[i].res);
      checkEq({pfx, "_mis"}, obsMis, vecs[i].mis);
      checkEq({pfx, "_ill"}, obsIll, vecs[i].ill);
      checkEq({pfx, "_tag"}, obsTag, i + 1);
   endtask

   // Entered and left at posedge+1.
   task automatic runOne(input int i);
      int cyc;
      int lat;
      bit accepted;
      bit seen;
      accepted = 0;
      seen = 0;
      cyc = 0;
      out_ready = 1'b1;
      drive(i);
      in_valid = 1'b1;
      while (!accepted && cyc < 20) begin
         @(negedge clock);
         if (obsInReady) accepted = 1;
         @(posedge clock); #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (!accepted) checkEq($sformatf("v%0d_accept_timeout", i), 0, 1);
      lat = 1;
      while (!seen && lat < 20) begin
         @(negedge clock);
         if (obsOutValid) seen = 1;
         else begin
            @(posedge clock); #1;
            lat++;
         end
      end
      checkEq($sformatf("v%0d_latency", i), lat, stagesCur);
      checkOut($sformatf("v%0d", i), i);
      @(posedge clock); #1;
      @(negedge clock);
      checkEq($sformatf("v%0d_drained", i), obsOutValid, 0);
      @(posedge clock); #1;
   endtask

   // Streams n vectors starting at 'first', one offered per cycle, with
   // out_ready low during cycles [stallAt, stallAt+stallLen).
   task automatic runStream(input int first, input int n, input int stallAt,
                            input int stallLen, input string pfx);
      int sent;
      int got;
      int cyc;
      bit stalled;
      bit heldValid;
      logic [XLEN-1:0]  heldRes;
      logic             heldMis, heldIll;
      logic [TAG_W-1:0] heldTag;
      sent = 0; got = 0; cyc = 0; heldValid = 0;
      heldRes = '0; heldMis = 0; heldIll = 0; heldTag = '0;
      while (got < n && cyc < 200) begin
         stalled = (cyc >= stallAt) && (cyc < stallAt + stallLen);
         out_ready = !stalled;
         if (sent < n) begin
            drive(first + sent);
            in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clock);
         if (obsOutValid && !stalled) begin
            checkOut($sformatf("%s_i%0d", pfx, got), first + got);
            got++;
            heldValid = 0;
         end else if (obsOutValid) begin
            if (heldValid) begin
               checkEq($sformatf("%s_hold_res_c%0d", pfx, cyc), obsRes, heldRes);
               checkEq($sformatf("%s_hold_tag_c%0d", pfx, cyc), obsTag, heldTag);
               checkEq($sformatf("%s_hold_flags_c%0d", pfx, cyc), {obsMis, obsIll}, {heldMis, heldIll});
            end
            heldValid = 1;
            heldRes = obsRes; heldMis = obsMis; heldIll = obsIll; heldTag = obsTag;
         end else heldValid = 0;
         if (stalled && cyc >= stallAt + 2)
            checkEq($sformatf("%s_full_in_ready_c%0d", pfx, cyc), obsInReady, 0);
         if (in_valid && obsInReady) sent++;
         @(posedge clock); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checkEq({pfx, "_count"}, got, n);
      if (stallLen == 0) checkEq({pfx, "_cycles"}, cyc, n + stagesCur);
      repeat (3) begin
         @(negedge clock);
         checkEq({pfx, "_no_extra"}, obsOutValid, 0);
         @(posedge clock); #1;
      end
   endtask

   task automatic resetAndCheck();
      reset = 1'b1;
      in_valid = 1'b1;
      drive(0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      checkEq("rst_in_ready", obsInReady, 1);
      checkEq("rst_out_valid", obsOutValid, 0);
      checkEq("rst_result", obsRes, 0);
      checkEq("rst_flags", {obsMis, obsIll}, 0);
      checkEq("rst_out_tag", obsTag, 0);
      @(posedge clock); #1;
   endtask

   task automatic midStreamReset();
      bit stale;
      stale = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(k);
         in_valid = 1'b1;
         @(posedge clock); #1;
      end
      out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checkEq("mid_rst_out_valid", obsOutValid, 0);
      checkEq("mid_rst_result", obsRes, 0);
      checkEq("mid_rst_out_tag", obsTag, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      checkEq("mid_rst_in_ready", obsInReady, 1);
      repeat (4) begin
         @(posedge clock); #1;
         @(negedge clock);
         if (obsOutValid) stale = 1;
      end
      checkEq("mid_rst_no_stale", stale, 0);
      @(posedge clock); #1;
      runOne(3);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      setVec(0,  LUI,    32'h123450B7, 32'h0,        32'h0,    32'h12345000, 0, 0);
      setVec(1,  AUIPC,  32'h00001097, 32'h100,      32'h0,    32'h00001100, 0, 0);
      setVec(2,  JAL,    32'h008000EF, 32'h200,      32'h0,    32'h00000208, 0, 0);
      setVec(3,  LINK,   32'h0,        32'h200,      32'h0,    32'h00000204, 0, 0);
      setVec(4,  BRANCH, 32'hFE000EE3, 32'h100,      32'h0,    32'h000000FC, 0, 0);
      setVec(5,  JALR,   32'h000100E7, 32'h0,        32'h1003, 32'h00001002, 1, 0);
      setVec(6,  4'hF,   32'h123450B7, 32'h100,      32'h55,   32'h0,        0, 1);
      setVec(7,  JAL,    32'h008000EF, 32'h202,      32'h0,    32'h0000020A, 1, 0);
      setVec(8,  AUIPC,  32'h80000097, 32'h80000000, 32'h0,    32'h0,        0, 0);
      setVec(9,  BRANCH, 32'hFE000EE3, 32'h102,      32'h0,    32'h000000FE, 1, 0);
      setVec(10, JALR,   32'hFFF00067, 32'h0,        32'h1000, 32'h00000FFE, 1, 0);
      setVec(11, 4'h6,   32'h008000EF, 32'h200,      32'h1000, 32'h0,        0, 1);

      for (int s = 0; s < 2; s++) begin
         sel = s;
         stagesCur = s + 1;
         resetAndCheck();
         for (int i = 0; i < NVEC; i++) runOne(i);
         runStream(2, 2, 1000, 0, "b2b_jal_link");
         runStream(0, NVEC, 1000, 0, "stream_all");
         runStream(0, NVEC, 2, 5, "stall");
         midStreamReset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
